// File: rtl/ct_spsram_pkg.sv
// Shared types and helpers for the banked single-port SRAM wrapper.
package ct_spsram_pkg;

  // Post-reset zeroing sequencer states
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Widest bank slice the parity helper accepts (slices are zero-extended)
  localparam int unsigned PAR_MAX_W = 256;

  // Even parity bit: makes the total number of ones (data + bit) even
  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

  // Ceiling log2, never below 1 so counters keep at least one bit
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ct_f_spsram_bank.sv
// One bank of the banked SRAM: DEPTH x (BANK_W+PAR_EN) array, one write port,
// one registered read port with synchronous clear. When PAR_EN is set the top
// bit of each word holds the stored parity and a mismatch is registered on read.
module ct_f_spsram_bank
  import ct_spsram_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BANK_W     = 25,
  parameter int unsigned PAR_EN     = 0
) (
  input  logic                       CLK,
  input  logic                       clr,
  input  logic                       we,
  input  logic                       re,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [BANK_W+PAR_EN-1:0]   wd,
  output logic [BANK_W-1:0]          rd,
  output logic                       perr
);

  localparam int unsigned SW = BANK_W + PAR_EN;

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] rword;

  assign rword = mem[addr];

  // Array write; contents are only ever initialised by the top's zeroing pass
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wd;
  end

  // Registered read data, held when no read is issued
  always_ff @(posedge CLK) begin
    if (clr)     rd <= '0;
    else if (re) rd <= rword[BANK_W-1:0];
  end

  if (PAR_EN != 0) begin : g_par
    // Registered parity mismatch, updated alongside rd
    always_ff @(posedge CLK) begin
      if (clr)     perr <= 1'b0;
      else if (re) perr <= parity_even(PAR_MAX_W'(rword[BANK_W-1:0])) ^ rword[SW-1];
    end
  end else begin : g_nopar
    assign perr = 1'b0;
  end

endmodule

// File: rtl/ct_f_spsram_banked.sv
// Parametrised single-port SRAM wrapper: N_BANK byte-lane style banks with
// per-bank write enables, registered/held read data, post-reset zeroing of the
// whole array and range checking for non-power-of-two depths.
// Optional per-bank parity with injection hook: define CT_SPSRAM_PARITY_EN.
module ct_f_spsram_banked
  import ct_spsram_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 100,
  parameter int unsigned BANK_W     = 25,
  localparam int unsigned N_BANK    = WIDTH / BANK_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [N_BANK-1:0]     WEN,
  input  logic [WIDTH-1:0]      D,
  output logic [WIDTH-1:0]      Q,
  output logic                  INIT_BUSY,
  output logic [N_BANK-1:0]     PAR_ERR
`ifdef CT_SPSRAM_PARITY_EN
  ,
  input  logic [N_BANK-1:0]     PAR_INJ
`endif
);

`ifdef CT_SPSRAM_PARITY_EN
  localparam int unsigned PAR_EN = 1;
`else
  localparam int unsigned PAR_EN = 0;
`endif
  localparam int unsigned SW    = BANK_W + PAR_EN;
  localparam int unsigned CNT_W = clog2_f(DEPTH);

  init_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;

  // Init sequencer state, counter and busy flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == INIT);
    end
  end

  // Next state: sweep every address once, then hand the array to the user
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign INIT_BUSY = busy_q;

  logic                  init_wr, in_rng, usr_acc, usr_wr, usr_rd, oob_rd, rd_clr;
  logic [ADDR_WIDTH-1:0] addr;

  // Access decode; user traffic is ignored during reset and the zeroing pass
  assign init_wr = (state_q == INIT);
  assign in_rng  = (32'(A) < DEPTH);
  assign usr_acc = !RST && (state_q == READY) && !CEN;
  assign usr_wr  = usr_acc && !GWEN && in_rng;
  assign usr_rd  = usr_acc &&  GWEN && in_rng;
  assign oob_rd  = usr_acc &&  GWEN && !in_rng;
  assign rd_clr  = RST || oob_rd;
  assign addr    = init_wr ? ADDR_WIDTH'(cnt_q) : A;

  for (genvar g = 0; g < N_BANK; g++) begin : g_bank
    logic [SW-1:0] wd;
    logic          we;

    // Zero word during init, otherwise the user slice (plus its parity)
`ifdef CT_SPSRAM_PARITY_EN
    assign wd = init_wr ? '0
              : {parity_even(PAR_MAX_W'(D[g*BANK_W +: BANK_W])) ^ PAR_INJ[g],
                 D[g*BANK_W +: BANK_W]};
`else
    assign wd = init_wr ? '0 : D[g*BANK_W +: BANK_W];
`endif
    assign we = init_wr || (usr_wr && !WEN[g]);

    ct_f_spsram_bank #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BANK_W     (BANK_W),
      .PAR_EN     (PAR_EN)
    ) u_bank (
      .CLK  (CLK),
      .clr  (rd_clr),
      .we   (we),
      .re   (usr_rd),
      .addr (addr),
      .wd   (wd),
      .rd   (Q[g*BANK_W +: BANK_W]),
      .perr (PAR_ERR[g])
    );
  end

endmodule

// File: tb/tb_ct_f_spsram_banked.sv
// Bench for ct_f_spsram_banked: a 256-deep and a 200-deep instance share one
// stimulus stream; a word-level memory model predicts Q/INIT_BUSY/PAR_ERR.
module tb_ct_f_spsram_banked;

  localparam int unsigned W  = 100;
  localparam int unsigned BW = 25;
  localparam int unsigned NB = 4;
  localparam int unsigned AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [NB-1:0] WEN, INJ;
  logic [W-1:0]  D;

  logic [W-1:0]  q    [2];
  logic          busy [2];
  logic [NB-1:0] perr [2];

  always #5 CLK = ~CLK;

  ct_f_spsram_banked #(.DEPTH(256), .ADDR_WIDTH(AW), .WIDTH(W), .BANK_W(BW)) u_d256 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q[0]), .INIT_BUSY(busy[0]), .PAR_ERR(perr[0])
`ifdef CT_SPSRAM_PARITY_EN
    , .PAR_INJ(INJ)
`endif
  );

  ct_f_spsram_banked #(.DEPTH(200), .ADDR_WIDTH(AW), .WIDTH(W), .BANK_W(BW)) u_d200 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q[1]), .INIT_BUSY(busy[1]), .PAR_ERR(perr[1])
`ifdef CT_SPSRAM_PARITY_EN
    , .PAR_INJ(INJ)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0]  mdl   [2][256];
  logic [NB-1:0] minj  [2][256];
  int            busy_left [2];
  logic [W-1:0]  mq    [2];
  logic [NB-1:0] mperr [2];

  function automatic int unsigned dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  // Word-level behaviour: reset zeroes everything and blocks access for DEPTH cycles
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        busy_left[k] = int'(dep(k));
        mq[k]        = '0;
        mperr[k]     = '0;
        for (int j = 0; j < 256; j++) begin
          mdl[k][j]  = '0;
          minj[k][j] = '0;
        end
      end else if (busy_left[k] > 0) begin
        busy_left[k]--;
      end else if (!CEN) begin
        if (32'(A) < dep(k)) begin
          if (GWEN) begin
            mq[k]    = mdl[k][A];
            mperr[k] = minj[k][A];
          end else begin
            for (int b = 0; b < NB; b++) begin
              if (!WEN[b]) begin
                mdl[k][A][b*BW +: BW] = D[b*BW +: BW];
`ifdef CT_SPSRAM_PARITY_EN
                minj[k][A][b] = INJ[b];
`endif
              end
            end
          end
        end else if (GWEN) begin
          mq[k]    = '0;
          mperr[k] = '0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("q_dut%0d", k),    q[k],           mq[k]);
        chk($sformatf("busy_dut%0d", k), W'(busy[k]),    W'(busy_left[k] > 0));
        chk($sformatf("perr_dut%0d", k), W'(perr[k]),    W'(mperr[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic cen, input logic gwen, input logic [NB-1:0] wen,
                     input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] inj);
    CEN = cen; GWEN = gwen; WEN = wen; A = a; D = d; INJ = inj;
    @(negedge CLK);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b0, 1'b1, '1, a, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] wen,
                    input logic [W-1:0] d, input logic [NB-1:0] inj);
    cyc(1'b0, 1'b0, wen, a, d, inj);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, '1, '0, '0, '0);
  endtask

  task automatic count_busy(output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int t = 0; t < 1000; t++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (!busy[0] && !busy[1]) break;
      @(negedge CLK);
    end
  endtask

  logic [W-1:0] exp_bank;
  logic [W-1:0] pat1, pat2;
  int n0, n1;

  initial begin
    RST = 1'b1; A = '0; CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; INJ = '0;
    pat1 = 100'h123456789ABCDEF0123456789;
    pat2 = 100'hFEDCBA9876543210FEDCBA987;
    exp_bank = '0;
    exp_bank[24:0]  = '1;
    exp_bank[74:50] = '1;

    @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_busy", W'(busy[0]), W'(1'b1));
    chk("rst_q",    q[0],        '0);
    chk("rst_perr", W'(perr[0]), '0);

    // Zeroing pass length
    RST = 1'b0;
    count_busy(n0, n1);
    chk("init_len_256", W'(n0), W'(256));
    chk("init_len_200", W'(n1), W'(200));

    // Fresh array reads back zero
    rd(8'd0);   chk("init_rd0",   q[0], '0);
    rd(8'd128); chk("init_rd128", q[0], '0);
    rd(8'd255); chk("init_rd255", q[0], '0);

    // Banked write: only banks 0 and 2 enabled
    wr(8'd5, 4'b1010, '1, '0);
    rd(8'd5);   chk("bank_wr", q[0], exp_bank);

    // Hold across idle and write cycles
    idle(); idle(); idle();
    chk("hold_idle", q[0], exp_bank);
    wr(8'd5, 4'b0000, pat1, '0);
    chk("hold_wr", q[0], exp_bank);
    rd(8'd5);   chk("rd_after_wr", q[0], pat1);

    // Range check on the 200-deep instance
    wr(8'd210, 4'b0000, W'(3), '0);
    rd(8'd210);
    chk("oob_rd_200",  q[1], '0);
    chk("inrng_rd_256", q[0], W'(3));
    rd(8'd199); chk("no_alias_199", q[1], '0);
    wr(8'd199, 4'b0000, pat2, '0);
    rd(8'd199); chk("last_addr_200", q[1], pat2);

`ifdef CT_SPSRAM_PARITY_EN
    wr(8'd7, 4'b0000, pat1, 4'b0100);
    rd(8'd7);   chk("par_inj", W'(perr[0]), W'(4'b0100));
    rd(8'd8);   chk("par_clr", W'(perr[0]), '0);
`endif

    // Reset in the middle of the zeroing pass restarts it
    RST = 1'b1; idle();
    RST = 1'b0;
    for (int i = 0; i < 100; i++) idle();
    RST = 1'b1; idle();
    RST = 1'b0;
    count_busy(n0, n1);
    chk("reinit_len_256", W'(n0), W'(256));
    chk("reinit_len_200", W'(n1), W'(200));
    rd(8'd5);   chk("rezeroed", q[0], '0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
